// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//  Shared definitions for the BCD counter/decoder slice.
//  BCD_W         width of one BCD digit
//  BCD_MAX       largest legal digit value
//  bcd_onehot    nibble -> 10-line one-hot (all zero for an illegal nibble)
//  bcd_sanitise  nibble -> itself when 0..9, otherwise 0
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int             BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  function automatic logic [9:0] bcd_onehot(input logic [BCD_W-1:0] nibble);
    logic [9:0] res;
    res = '0;
    if (nibble <= BCD_MAX) res[nibble] = 1'b1;
    return res;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_sanitise(input logic [BCD_W-1:0] nibble);
    return (nibble > BCD_MAX) ? '0 : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
//  One decade of the cascaded BCD up/down counter.
//  Ports:
//    clk, rstn   clock, asynchronous active-low reset
//    load, ld    parallel load strobe and value (sanitised to 0..9 on load)
//    step        count enable shared by all decades
//    up          direction: 1 = increment, 0 = decrement
//    cin         ripple in from the less-significant decade (1 for digit 0)
//    q           current digit value, always 0..9
//    cout        ripple out: this decade is rolling over on this edge
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [BCD_W-1:0] ld,
  input  logic             step,
  input  logic             up,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // decade samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (load) begin
      q <= bcd_sanitise(ld);
    end else if (step && cin) begin
      if (up) q <= (q == BCD_MAX) ? '0 : q + 4'd1;
      else    q <= (q == '0) ? BCD_MAX : q - 4'd1;
    end
  end

  // Rollover is combinational so a full-width ripple settles within one cycle.
  assign cout = step & cin & (up ? (q == BCD_MAX) : (q == '0));

endmodule

// File: rtl/bcd_count_dec.sv
// -----------------------------------------------------------------------------
// bcd_count_dec
//  N-digit cascaded BCD up/down counter with a time-multiplexed one-hot digit
//  decoder for a scanned numeric display.
//  Parameters:
//    DIGITS    number of BCD decades (>=1)
//    SCAN_DIV  cycles each digit stays selected during scan (>=1)
//  Ports:
//    clk, rstn  clock, asynchronous active-low reset
//    en, up     count enable / direction (1 = up)
//    load       parallel load strobe, wins over en
//    load_val   BCD value to load, digit 0 in [3:0]
//    count      current BCD count, digit 0 in [3:0]
//    carry      registered one-cycle pulse on full-range wrap
//    scan_sel   one-hot select of the digit currently scanned
//    o          one-hot decode of the scanned digit
//  Build option: BCD_COUNT_DEC_BLANK_EN enables leading-zero blanking (o=0 for
//  any digit above the most-significant nonzero digit; digit 0 never blanked).
// -----------------------------------------------------------------------------
module bcd_count_dec
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16
)(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    carry,
  output logic [DIGITS-1:0]       scan_sel,
  output logic [9:0]              o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // ---------------------------------------------------------------- counter
  logic [DIGITS:0] chain;
  assign chain[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk  (clk),
      .rstn (rstn),
      .load (load),
      .ld   (load_val[g*BCD_W +: BCD_W]),
      .step (en),
      .up   (up),
      .cin  (chain[g]),
      .q    (count[g*BCD_W +: BCD_W]),
      .cout (chain[g+1])
    );
  end

  // A ripple out of the top decade is exactly the full-range wrap; load
  // overrides counting, so it also suppresses the pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) carry <= 1'b0;
    else       carry <= chain[DIGITS] & ~load;
  end

  // ---------------------------------------------------------------- scan
  logic [DIV_W-1:0] div;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // ---------------------------------------------------------------- decode
  logic [BCD_W-1:0] cur;
  logic             blank_cur;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    scan_sel  = '0;
    cur       = '0;
    blank_cur = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        scan_sel[i] = 1'b1;
        cur         = count[i*BCD_W +: BCD_W];
`ifdef BCD_COUNT_DEC_BLANK_EN
        // Blank when this digit and every higher one are zero.
        blank_cur   = (i != 0) && ((count >> (BCD_W*i)) == '0);
`endif
      end
    end
    o = blank_cur ? 10'b0 : bcd_onehot(cur);
  end

endmodule

// File: tb/tb_bcd_count_dec.sv
// -----------------------------------------------------------------------------
// tb_bcd_count_dec
//  Scoreboard bench for bcd_count_dec (DIGITS=4, SCAN_DIV=2). The stimulus
//  process drives one cycle at a time, advances an integer-valued reference
//  model (count as 0..9999, scan position from cycles since reset) and pushes
//  the expectation; a monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_bcd_count_dec;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 2;
  localparam int W        = 4 * DIGITS;
  localparam int MOD      = 10000;

  logic         clk = 1'b0;
  logic         rstn, en, up, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         carry;
  logic [DIGITS-1:0] scan_sel;
  logic [9:0]   o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int cnt;
    bit carry;
    int ticks;
  } exp_t;

  exp_t sb[$];

  // model state
  int m_cnt   = 0;
  int m_ticks = 0;

  bcd_count_dec #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .carry    (carry),
    .scan_sel (scan_sel),
    .o        (o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r *= 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int load_to_int(input logic [W-1:0] lv);
    int r = 0;
    for (int i = 0; i < DIGITS; i++) begin
      int d = int'(lv[i*4 +: 4]);
      if (d > 9) d = 0;
      r += d * pow10(i);
    end
    return r;
  endfunction

  function automatic logic [9:0] exp_o(input int cnt, input int idx);
    int d = (cnt / pow10(idx)) % 10;
`ifdef BCD_COUNT_DEC_BLANK_EN
    if (idx > 0 && cnt < pow10(idx)) return 10'b0;
`endif
    return 10'(1) << d;
  endfunction

  // monitor
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      int   idx;
      e   = sb.pop_front();
      idx = (e.ticks / SCAN_DIV) % DIGITS;
      check("count",    32'(count),    32'(to_bcd(e.cnt)));
      check("carry",    32'(carry),    32'(e.carry));
      check("scan_sel", 32'(scan_sel), 32'(1 << idx));
      check("o",        32'(o),        32'(exp_o(e.cnt, idx)));
    end
  end

  // One clock cycle of stimulus; called just after a falling edge.
  task automatic cyc(input bit ld, input logic [W-1:0] lv, input bit e, input bit u);
    exp_t x;
    load = ld; load_val = lv; en = e; up = u;
    @(posedge clk);
    x.carry = 1'b0;
    if (ld) begin
      m_cnt = load_to_int(lv);
    end else if (e) begin
      if (u) begin
        x.carry = (m_cnt == MOD - 1);
        m_cnt   = (m_cnt + 1) % MOD;
      end else begin
        x.carry = (m_cnt == 0);
        m_cnt   = (m_cnt + MOD - 1) % MOD;
      end
    end
    m_ticks++;
    x.cnt   = m_cnt;
    x.ticks = m_ticks;
    sb.push_back(x);
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
    #11;
    check("reset_count", 32'(count), 32'h0);
    check("reset_o", 32'(o), 32'h001);
    rstn = 1'b1;   // released at t=11, before the rising edge at t=15

    // 1: asynchronous reset with no clock edge
    cyc(1'b1, 16'h0042, 1'b0, 1'b0);
    check("pre_reset_count", 32'(count), 32'h0042);
    rstn = 1'b0;
    #1;
    check("async_count",    32'(count),    32'h0);
    check("async_carry",    32'(carry),    32'h0);
    check("async_scan_sel", 32'(scan_sel), 32'h1);
    check("async_o",        32'(o),        32'h001);
    m_cnt = 0; m_ticks = 0;
    #1 rstn = 1'b1;

    // 2: count up
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b1);
    check("up10", 32'(count), 32'h0010);
    for (int i = 0; i < 90; i++) cyc(1'b0, '0, 1'b1, 1'b1);
    check("up100", 32'(count), 32'h0100);

    // 3: wrap both ways
    cyc(1'b1, 16'h9999, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check("wrap_up_count", 32'(count), 32'h0000);
    check("wrap_up_carry", 32'(carry), 32'h1);
    hold(1);
    check("wrap_up_carry_end", 32'(carry), 32'h0);
    cyc(1'b1, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("wrap_dn_count", 32'(count), 32'h9999);
    check("wrap_dn_carry", 32'(carry), 32'h1);

    // 4: load beats a would-be wrap; sanitising
    cyc(1'b1, 16'h1234, 1'b1, 1'b1);
    check("load_prio_count", 32'(count), 32'h1234);
    check("load_prio_carry", 32'(carry), 32'h0);
    cyc(1'b1, 16'h12A4, 1'b1, 1'b0);
    check("load_sanitise", 32'(count), 32'h1204);

    // 5: scan of a held value over two full rotations
    cyc(1'b1, 16'h5031, 1'b0, 1'b0);
    hold(2 * DIGITS * SCAN_DIV);

    // 6: blanking patterns (decode checked by monitor in either build)
    cyc(1'b1, 16'h0031, 1'b0, 1'b0);
    hold(DIGITS * SCAN_DIV);
    cyc(1'b1, 16'h0000, 1'b0, 1'b0);
    hold(DIGITS * SCAN_DIV);

    // randomized mix
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] lv;
      int sel;
      sel = int'($urandom_range(0, 19));
      lv  = 16'($urandom);
      if (sel == 0) lv = 16'h9999;
      if (sel == 1) lv = 16'h0000;
      cyc((sel < 3), lv, 1'($urandom), 1'($urandom));
    end

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
